// File: rtl/alu_pkg.sv
// ALU execute-stage shared definitions: ALUOp encodings, 4-bit ALU control codes,
// FSM state type and the is_shift() classifier.
// Latency: n/a (constants and pure function). Backpressure: n/a.
package alu_pkg;

  // ALUOp field produced by the main decoder
  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  // 4-bit ALU control codes; bit 3 marks the "alternate" form (SUB / SRA)
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  function automatic logic is_shift(input logic [3:0] ctrl);
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the ID/EX register, the execute unit and EX/MEM.
// Latency: n/a (wiring only). Backpressure: in_valid/in_ready upstream, out_valid/out_ready downstream.
// slave = execute unit; master = pipeline side (drives requests, consumes results).
interface alu_exec_unit_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      alu_op;
  logic [2:0]      funct3;
  logic            funct7;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic [3:0]      alu_ctrl;
  logic            busy;

  modport master (
    output in_valid, alu_op, funct3, funct7, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, alu_ctrl, busy
  );

  modport slave (
    input  in_valid, alu_op, funct3, funct7, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, alu_ctrl, busy
  );
endinterface

// File: rtl/alu_decode.sv
// ALU control decode: alu_op/funct3/funct7 -> 4-bit ALU control code.
// Latency: purely combinational. Backpressure: none.
// Ports: alu_op_i, funct3_i, funct7_i (instr bit 30) in; alu_ctrl_o out.
module alu_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_i,
  output logic [3:0] alu_ctrl_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_MEM:    alu_ctrl_o = ALU_ADD;
      ALUOP_BRANCH: alu_ctrl_o = ALU_SUB;
      default: begin
        case (funct3_i)
          // I-type has no SUB: bit 30 is part of the immediate there
          3'b000:  alu_ctrl_o = (alu_op_i == ALUOP_RTYPE && funct7_i) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl_o = ALU_SLL;
          3'b010:  alu_ctrl_o = ALU_SLT;
          3'b011:  alu_ctrl_o = ALU_SLTU;
          3'b100:  alu_ctrl_o = ALU_XOR;
          // SRAI keeps bit 30 as opcode, so both forms honour funct7
          3'b101:  alu_ctrl_o = funct7_i ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl_o = ALU_OR;
          default: alu_ctrl_o = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: decode + single-cycle ALU ops, iterative barrel for shifts, registered result.
// Latency: 1 edge for non-shift ops; max(1, ceil(shamt/SHIFT_STEP)) SHIFT-state edges for shifts.
// Backpressure: in_ready low in SHIFT or while a result is held with out_ready low; result held stable until drained.
// Ports: clk, reset (async active-high), flush (sync abort), io (slave side of alu_exec_unit_if).
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int SHIFT_STEP = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  alu_exec_unit_if.slave io
);

  localparam int SHAMT_W = $clog2(XLEN);
  // Step width in both the compare domain (one extra bit so STEP==XLEN fits)
  // and the remainder domain (only used when rem > STEP, so never truncated in use)
  localparam logic [SHAMT_W:0]   STEP_EXT = (SHAMT_W+1)'(SHIFT_STEP);
  localparam logic [SHAMT_W-1:0] STEP_REM = SHAMT_W'(SHIFT_STEP);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [3:0]        sh_ctrl_q, sh_ctrl_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              zero_q, zero_d;
  logic [3:0]        ctrl_q, ctrl_d;
  logic              out_valid_q, out_valid_d;

  logic [3:0]        dec_ctrl;
  logic [XLEN-1:0]   alu_res;
  logic              accept;
  logic [SHAMT_W:0]  rem_ext;
  logic              last_step;
  logic [SHAMT_W:0]  step_amt;
  logic [XLEN-1:0]   acc_shifted;

  alu_decode u_decode (
    .alu_op_i   (io.alu_op),
    .funct3_i   (io.funct3),
    .funct7_i   (io.funct7),
    .alu_ctrl_o (dec_ctrl)
  );

  // Ready depends only on state and the output register, never on in_valid
  assign io.in_ready  = (state_q == ST_IDLE) && (!out_valid_q || io.out_ready);
  assign accept       = io.in_valid && io.in_ready;
  assign io.out_valid = out_valid_q;
  assign io.result    = result_q;
  assign io.zero      = zero_q;
  assign io.alu_ctrl  = ctrl_q;
  assign io.busy      = (state_q == ST_SHIFT);

  always_comb begin
    alu_res = '0;
    case (dec_ctrl)
      ALU_ADD:  alu_res = io.op_a + io.op_b;
      ALU_SUB:  alu_res = io.op_a - io.op_b;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(io.op_a) < $signed(io.op_b)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, io.op_a < io.op_b};
      ALU_XOR:  alu_res = io.op_a ^ io.op_b;
      ALU_OR:   alu_res = io.op_a | io.op_b;
      ALU_AND:  alu_res = io.op_a & io.op_b;
      default:  alu_res = '0;
    endcase
  end

  // One barrel step: shift by min(rem, SHIFT_STEP)
  assign rem_ext   = {1'b0, rem_q};
  assign last_step = (rem_ext <= STEP_EXT);
  assign step_amt  = last_step ? rem_ext : STEP_EXT;

  always_comb begin
    acc_shifted = acc_q;
    case (sh_ctrl_q)
      ALU_SLL: acc_shifted = acc_q << step_amt;
      ALU_SRA: acc_shifted = $unsigned($signed(acc_q) >>> step_amt);
      default: acc_shifted = acc_q >> step_amt;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    sh_ctrl_d   = sh_ctrl_q;
    result_d    = result_q;
    zero_d      = zero_q;
    ctrl_d      = ctrl_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && io.out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_shift(dec_ctrl)) begin
            acc_d     = io.op_a;
            rem_d     = io.op_b[SHAMT_W-1:0];
            sh_ctrl_d = dec_ctrl;
            state_d   = ST_SHIFT;
          end else begin
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            ctrl_d      = dec_ctrl;
            out_valid_d = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        acc_d = acc_shifted;
        if (last_step) begin
          result_d    = acc_shifted;
          zero_d      = (acc_shifted == '0);
          ctrl_d      = sh_ctrl_q;
          out_valid_d = 1'b1;
          rem_d       = '0;
          state_d     = ST_IDLE;
        end else begin
          rem_d = rem_q - STEP_REM;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush wins over any accept or completion in the same cycle
    if (flush) begin
      state_d     = ST_IDLE;
      acc_d       = '0;
      rem_d       = '0;
      result_d    = result_q;
      zero_d      = zero_q;
      ctrl_d      = ctrl_q;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      rem_q       <= '0;
      sh_ctrl_q   <= ALU_ADD;
      result_q    <= '0;
      zero_q      <= 1'b1;
      ctrl_q      <= ALU_ADD;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      sh_ctrl_q   <= sh_ctrl_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ctrl_q      <= ctrl_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit (XLEN=64, SHIFT_STEP=8): directed cases then random traffic.
// Expected results come from a behavioural model using plain SV operators.
// A monitor pops the expectation queue whenever a result is drained.
`timescale 1ns/1ps
module tb_alu_exec_unit;

  localparam int XLEN = 64;
  localparam int STEP = 8;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  always #5 clk = ~clk;

  alu_exec_unit_if #(.XLEN(XLEN)) bus();

  alu_exec_unit #(.XLEN(XLEN), .SHIFT_STEP(STEP)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .io    (bus)
  );

  typedef struct {
    logic [63:0] res;
    logic [3:0]  ctrl;
  } exp_t;

  exp_t exp_q[$];
  bit   rdy_pat[$];
  bit   rnd_rdy = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural reference: decode table + plain-operator semantics; lat is the
  // number of edges after the accept edge before out_valid is visible
  function automatic void ref_model(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                                    input logic [63:0] a, input logic [63:0] b,
                                    output logic [3:0] ctrl, output logic [63:0] res, output int lat);
    int sh;
    sh   = int'(b[5:0]);
    ctrl = 4'b0000;
    if (op == 2'b00)      ctrl = 4'b0000;
    else if (op == 2'b01) ctrl = 4'b1000;
    else begin
      case (f3)
        3'd0: ctrl = (op == 2'b10 && f7) ? 4'b1000 : 4'b0000;
        3'd1: ctrl = 4'b0001;
        3'd2: ctrl = 4'b0010;
        3'd3: ctrl = 4'b0011;
        3'd4: ctrl = 4'b0100;
        3'd5: ctrl = f7 ? 4'b1101 : 4'b0101;
        3'd6: ctrl = 4'b0110;
        default: ctrl = 4'b0111;
      endcase
    end
    lat = 0;
    case (ctrl)
      4'b0000: res = a + b;
      4'b1000: res = a - b;
      4'b0010: res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'b0011: res = (a < b) ? 64'd1 : 64'd0;
      4'b0100: res = a ^ b;
      4'b0110: res = a | b;
      4'b0111: res = a & b;
      4'b0001: res = a << sh;
      4'b0101: res = a >> sh;
      default: res = 64'($signed(a) >>> sh);
    endcase
    if (ctrl == 4'b0001 || ctrl == 4'b0101 || ctrl == 4'b1101)
      lat = (sh == 0) ? 1 : (sh + STEP - 1) / STEP;
  endfunction

  // Downstream ready: explicit pattern first, else random or always-ready
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_pat.size() > 0) bus.out_ready = rdy_pat.pop_front();
      else if (rnd_rdy)       bus.out_ready = ($urandom_range(0, 99) < 65);
      else                    bus.out_ready = 1'b1;
    end
  end

  // Monitor: handshake rule, stall stability and scoreboard compare
  bit          stalled = 1'b0;
  logic [63:0] st_res;
  logic [3:0]  st_ctrl;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      stalled = 1'b0;
    end else begin
      check("in_ready rule", bus.in_ready, !bus.busy && (!bus.out_valid || bus.out_ready));
      if (stalled) begin
        check("stall out_valid", bus.out_valid, 1'b1);
        check("stall result", bus.result, st_res);
        check("stall alu_ctrl", bus.alu_ctrl, st_ctrl);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected out_valid", bus.out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("result", bus.result, e.res);
          check("alu_ctrl", bus.alu_ctrl, e.ctrl);
          check("zero", bus.zero, e.res == 64'd0);
        end
      end
      stalled = bus.out_valid && !bus.out_ready && !flush;
      st_res  = bus.result;
      st_ctrl = bus.alu_ctrl;
    end
  end

  // Called just after a posedge; returns just after a posedge
  task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                       input logic [63:0] a, input logic [63:0] b, input bit chk_lat, input string tag);
    exp_t e;
    logic [3:0]  c;
    logic [63:0] r;
    int lat, got_lat, busy_cnt;
    bit ok;
    ref_model(op, f3, f7, a, b, c, r, lat);
    e.res = r;
    e.ctrl = c;
    bus.in_valid = 1'b1;
    bus.alu_op = op;
    bus.funct3 = f3;
    bus.funct7 = f7;
    bus.op_a = a;
    bus.op_b = b;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      check({tag, " accept timeout"}, 64'd0, 64'd1);
      bus.in_valid = 1'b0;
      return;
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (chk_lat) begin
      got_lat = 0;
      busy_cnt = 0;
      ok = 1'b0;
      for (int n = 0; n < 100; n++) begin
        @(negedge clk);
        if (bus.out_valid) begin ok = 1'b1; break; end
        if (bus.busy) begin
          busy_cnt++;
          check({tag, " in_ready while busy"}, bus.in_ready, 1'b0);
        end
        @(posedge clk); #1;
        got_lat++;
      end
      check({tag, " out_valid timeout"}, ok, 1'b1);
      check({tag, " latency"}, 64'(got_lat), 64'(lat));
      check({tag, " busy cycles"}, 64'(busy_cnt), 64'(lat));
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 400; n++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    check({tag, " drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " out_valid"}, bus.out_valid, 1'b0);
    check({tag, " result"}, bus.result, 64'd0);
    check({tag, " zero"}, bus.zero, 1'b1);
    check({tag, " alu_ctrl"}, bus.alu_ctrl, 4'b0000);
    check({tag, " busy"}, bus.busy, 1'b0);
    check({tag, " in_ready"}, bus.in_ready, 1'b1);
  endtask

  task automatic expect_quiet(input string tag);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check({tag, " no out_valid"}, bus.out_valid, 1'b0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a, b;
    logic [1:0]  op;
    logic [2:0]  f3;
    logic        f7;
    reset = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.alu_op = 2'b00;
    bus.funct3 = 3'b000;
    bus.funct7 = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk); #1;

    // Directed cases
    issue(2'b00, 3'b000, 1'b0, 64'd5, 64'd7, 1'b1, "add");
    issue(2'b10, 3'b000, 1'b1, 64'h1234, 64'h1234, 1'b1, "sub_r");
    issue(2'b11, 3'b000, 1'b1, 64'h1234, 64'h1234, 1'b1, "add_i");
    issue(2'b10, 3'b101, 1'b1, 64'h8000_0000_0000_0000, 64'd63, 1'b1, "sra63");
    issue(2'b10, 3'b001, 1'b0, 64'hdead_beef_0123_4567, 64'h40, 1'b1, "sll0");
    issue(2'b10, 3'b011, 1'b0, 64'd1, 64'hffff_ffff_ffff_ffff, 1'b1, "sltu");
    issue(2'b10, 3'b010, 1'b0, 64'd1, 64'hffff_ffff_ffff_ffff, 1'b1, "slt");
    issue(2'b11, 3'b101, 1'b0, 64'hf000_0000_0000_00f0, 64'd16, 1'b1, "srli16");
    issue(2'b01, 3'b000, 1'b0, 64'd3, 64'd5, 1'b1, "branch_sub");
    drain("directed");

    // Back-to-back logic ops against a stalling consumer
    rdy_pat.push_back(1'b1);
    rdy_pat.push_back(1'b0);
    rdy_pat.push_back(1'b0);
    rdy_pat.push_back(1'b1);
    issue(2'b10, 3'b111, 1'b0, 64'hff00_ff00_ff00_ff00, 64'h0ff0_0ff0_0ff0_0ff0, 1'b0, "and");
    issue(2'b10, 3'b110, 1'b0, 64'h1111_0000_2222_0000, 64'h0000_3333_0000_4444, 1'b0, "or");
    issue(2'b10, 3'b100, 1'b0, 64'haaaa_5555_aaaa_5555, 64'hffff_ffff_0000_0000, 1'b0, "xor");
    drain("b2b");

    // Reset pulse mid-shift: SRL by 40 must never produce a result
    issue(2'b10, 3'b101, 1'b0, 64'hffff_ffff_ffff_ffff, 64'd40, 1'b0, "srl_rst");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("midshift reset");
    @(posedge clk); #1;
    expect_quiet("after reset");
    issue(2'b00, 3'b000, 1'b0, 64'd100, 64'd23, 1'b1, "add_after_reset");
    drain("after reset");

    // Flush on the same cycle position
    issue(2'b10, 3'b101, 1'b0, 64'hffff_ffff_ffff_ffff, 64'd40, 1'b0, "srl_flush");
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush busy", bus.busy, 1'b0);
    @(posedge clk); #1;
    expect_quiet("after flush");
    issue(2'b00, 3'b000, 1'b0, 64'hffff_ffff_ffff_ffff, 64'd1, 1'b1, "add_after_flush");
    drain("after flush");

    // Random traffic with random consumer stalls
    rnd_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      op = 2'($urandom_range(0, 3));
      f3 = 3'($urandom_range(0, 7));
      f7 = 1'($urandom_range(0, 1));
      a  = {$urandom(), $urandom()};
      b  = {$urandom(), $urandom()};
      case ($urandom_range(0, 7))
        0: a = 64'd0;
        1: a = 64'hffff_ffff_ffff_ffff;
        2: a = 64'h8000_0000_0000_0000;
        3: b = a;
        4: b = 64'($urandom_range(0, 9)) * 64'd8;
        default: ;
      endcase
      issue(op, f3, f7, a, b, ($urandom_range(0, 4) == 0), "rnd");
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) begin
          @(posedge clk); #1;
        end
      end
    end
    drain("random");
    rnd_rdy = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
